// File: rtl/dense_to_coo_encoder.sv
// rtl/dense_to_coo_encoder.sv - dense DIMxDIM matrix to row-major COO entry stream
module dense_to_coo_encoder #(
    parameter int DATA_W  = 32,
    parameter int DIM     = 4,
    parameter int IDX_W   = 2,
    parameter int MAX_NNZ = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIM*DATA_W-1:0] in_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [IDX_W-1:0]      out_row,
    output logic [IDX_W-1:0]      out_col,
    output logic                  out_last,
    output logic                  done,
    output logic [IDX_W+1:0]      nnz_count,
    output logic                  overflow
);

    localparam int N = DIM * DIM;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [IDX_W-1:0]      row_cnt;
    logic [N-1:0]          mask;
    logic [DIM*DATA_W-1:0] buffer [DIM];

    logic                  beat;
    logic                  first_beat;
    logic                  last_beat;
    logic                  xfer;
    logic [DIM-1:0]        row_bits;
    logic [N-1:0]          beat_mask;
    logic [N-1:0]          load_mask;
    logic [N-1:0]          rest_mask;
    logic [IDX_W-1:0]      sel_row;
    logic [IDX_W-1:0]      sel_col;
    logic                  cap_reached;

    assign in_ready   = rst_n && (state == LOAD);
    assign out_valid  = (state == EMIT);
    assign done       = (state == DONE);
    assign beat       = in_valid && in_ready;
    assign first_beat = beat && (row_cnt == '0);
    assign last_beat  = beat && (row_cnt == IDX_W'(DIM - 1));
    assign xfer       = out_valid && out_ready;

    // Any set bit marks an element as nonzero, regardless of sign.
    always_comb begin
        row_bits = '0;
        for (int c = 0; c < DIM; c++) begin
            row_bits[c] = |in_row[c*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        beat_mask = '0;
        for (int r = 0; r < DIM; r++) begin
            if (row_cnt == IDX_W'(r)) begin
                beat_mask[r*DIM +: DIM] = row_bits;
            end
        end
    end

    assign load_mask = first_beat ? beat_mask : (mask | beat_mask);

    // Scan downwards so the lowest set bit is the one that sticks.
    always_comb begin
        sel_row = '0;
        sel_col = '0;
        for (int r = DIM - 1; r >= 0; r--) begin
            for (int c = DIM - 1; c >= 0; c--) begin
                if (mask[r*DIM + c]) begin
                    sel_row = IDX_W'(r);
                    sel_col = IDX_W'(c);
                end
            end
        end
    end

    // Clearing the lowest set bit leaves exactly the entries still pending.
    assign rest_mask   = mask & (mask - {{(N-1){1'b0}}, 1'b1});
    assign cap_reached = (nnz_count == (IDX_W+2)'(MAX_NNZ - 1));

    assign out_data = buffer[sel_row][sel_col*DATA_W +: DATA_W];
    assign out_row  = sel_row;
    assign out_col  = sel_col;
    assign out_last = out_valid && ((rest_mask == '0) || cap_reached);

    always_comb begin
        state_next = state;
        case (state)
            LOAD: begin
                if (last_beat) begin
                    state_next = (load_mask != '0) ? EMIT : DONE;
                end
            end
            EMIT: begin
                if (xfer && out_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = LOAD;
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt   <= '0;
            mask      <= '0;
            nnz_count <= '0;
            overflow  <= 1'b0;
            for (int r = 0; r < DIM; r++) begin
                buffer[r] <= '0;
            end
        end else begin
            if (beat) begin
                buffer[row_cnt] <= in_row;
                mask            <= load_mask;
                row_cnt         <= last_beat ? '0 : row_cnt + IDX_W'(1);
                if (first_beat) begin
                    nnz_count <= '0;
                    overflow  <= 1'b0;
                end
            end
            if (xfer) begin
                mask      <= rest_mask;
                nnz_count <= nnz_count + (IDX_W+2)'(1);
                if (out_last) begin
                    overflow <= (rest_mask != '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_dense_to_coo_encoder.sv
// tb/tb_dense_to_coo_encoder.sv - table-driven scoreboard bench for dense_to_coo_encoder
module tb_dense_to_coo_encoder;

    localparam int DATA_W  = 32;
    localparam int DIM     = 4;
    localparam int IDX_W   = 2;
    localparam int MAX_NNZ = 4;
    localparam int EW      = DATA_W + 2*IDX_W + 1;

    typedef logic [DIM*DIM*DATA_W-1:0] mat_t;
    typedef logic [EW-1:0]             ent_t;

    typedef struct {
        string name;
        mat_t  mat;
        int    exp_nnz;
        bit    exp_ovf;
    } vec_t;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DIM*DATA_W-1:0] in_row;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [IDX_W-1:0]      out_row;
    logic [IDX_W-1:0]      out_col;
    logic                  out_last;
    logic                  done;
    logic [IDX_W+1:0]      nnz_count;
    logic                  overflow;

    int   checks;
    int   errors;
    int   valid_seen;
    ent_t sb[$];
    vec_t vecs[6];

    dense_to_coo_encoder #(
        .DATA_W (DATA_W),
        .DIM    (DIM),
        .IDX_W  (IDX_W),
        .MAX_NNZ(MAX_NNZ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_row   (in_row),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_row  (out_row),
        .out_col  (out_col),
        .out_last (out_last),
        .done     (done),
        .nnz_count(nnz_count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic mat_t set_el(input mat_t m, input int r, input int c, input logic [DATA_W-1:0] v);
        mat_t t;
        t = m;
        t[(r*DIM + c)*DATA_W +: DATA_W] = v;
        return t;
    endfunction

    // Scoreboard sampling: a valid&&ready seen at a negedge transfers on the next posedge.
    task automatic sample();
        ent_t got;
        if (out_valid) valid_seen++;
        if (out_valid && out_ready) begin
            got = {out_data, out_row, out_col, out_last};
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry actual=%0h required=none", got);
            end else begin
                chk("entry", 64'(got), 64'(sb.pop_front()));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
    endtask

    task automatic push_expected(input mat_t m, output int n_pushed);
        ent_t tmp[$];
        logic [DATA_W-1:0] v;
        for (int k = 0; k < DIM*DIM; k++) begin
            v = m[k*DATA_W +: DATA_W];
            if (v != '0 && tmp.size() < MAX_NNZ)
                tmp.push_back({v, IDX_W'(k / DIM), IDX_W'(k % DIM), 1'b0});
        end
        if (tmp.size() > 0) tmp[tmp.size()-1][0] = 1'b1;
        foreach (tmp[i]) sb.push_back(tmp[i]);
        n_pushed = tmp.size();
    endtask

    task automatic send_matrix(input mat_t m, input bit stall, output int n_exp);
        push_expected(m, n_exp);
        valid_seen = 0;
        for (int r = 0; r < DIM; r++) begin
            in_valid = 1'b1;
            in_row   = m[r*DIM*DATA_W +: DIM*DATA_W];
            tick();
            if (r == 0) begin
                chk("first_beat_nnz_clear", 64'(nnz_count), 64'(0));
                chk("first_beat_ovf_clear", 64'(overflow), 64'(0));
            end
            if (stall && r < DIM - 1) begin
                in_valid = 1'b0;
                in_row   = '1;
                tick();
                chk("stall_in_ready", 64'(in_ready), 64'(1));
            end
        end
        in_valid = 1'b0;
        in_row   = '0;
        chk("first_entry_latency", 64'(out_valid), 64'(n_exp > 0));
        chk("zero_done_latency", 64'(done), 64'(n_exp == 0));
    endtask

    task automatic wait_done(input int exp_nnz, input bit exp_ovf, input bit chk_lat);
        int cycles;
        cycles = 0;
        while (!done && cycles < 64) begin
            tick();
            cycles++;
        end
        chk("done_seen", 64'(done), 64'(1));
        if (chk_lat) chk("done_latency", 64'(cycles), 64'(exp_nnz));
        chk("nnz_count", 64'(nnz_count), 64'(exp_nnz));
        chk("overflow", 64'(overflow), 64'(exp_ovf));
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        tick();
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("back_to_load", 64'(in_ready), 64'(1));
    endtask

    initial begin
        mat_t m;
        int   n;

        checks     = 0;
        errors     = 0;
        valid_seen = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_row     = '0;
        out_ready  = 1'b1;

        m = '0;
        for (int i = 0; i < DIM; i++) m = set_el(m, i, i, 32'h1);
        vecs[0] = '{"identity", m, 4, 1'b0};
        vecs[1] = '{"all_zero", '0, 0, 1'b0};
        m = '0;
        m = set_el(m, 1, 1, 32'd5);
        for (int c = 0; c < DIM; c++) m = set_el(m, 3, c, 32'd7);
        vecs[2] = '{"overflow5", m, 4, 1'b1};
        m = '0;
        m = set_el(m, 0, 3, 32'h8000_0000);
        m = set_el(m, 2, 0, 32'hFFFF_FFFF);
        vecs[3] = '{"sign_bits", m, 2, 1'b0};
        m = '0;
        m = set_el(m, 0, 0, 32'd1);
        m = set_el(m, 1, 2, 32'd4);
        m = set_el(m, 3, 2, 32'd2);
        m = set_el(m, 3, 3, 32'd3);
        vecs[4] = '{"exact_cap", m, 4, 1'b0};
        m = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) m = set_el(m, r, c, 32'(r*DIM + c + 1));
        vecs[5] = '{"full_dense", m, 4, 1'b1};

        #3;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_nnz", 64'(nnz_count), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        foreach (vecs[i]) begin
            send_matrix(vecs[i].mat, 1'b0, n);
            wait_done(vecs[i].exp_nnz, vecs[i].exp_ovf, 1'b1);
            if (vecs[i].exp_nnz == 0) chk("zero_never_valid", 64'(valid_seen), 64'(0));
        end

        // Back-pressure: one entry held for three cycles before it is taken.
        m = set_el('0, 2, 3, 32'hDEAD_BEEF);
        out_ready = 1'b0;
        send_matrix(m, 1'b0, n);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_hold", 64'({out_data, out_row, out_col, out_last}),
                64'({32'hDEAD_BEEF, 2'd2, 2'd3, 1'b1}));
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        sample();
        wait_done(1, 1'b0, 1'b0);

        // Input stall: previous matrix results must persist until the first new beat.
        send_matrix(vecs[5].mat, 1'b0, n);
        wait_done(4, 1'b1, 1'b1);
        chk("hold_nnz_before_beat", 64'(nnz_count), 64'(4));
        chk("hold_ovf_before_beat", 64'(overflow), 64'(1));
        m = '0;
        m = set_el(m, 1, 0, 32'h1234);
        m = set_el(m, 2, 2, 32'hFFFF_FFFB);
        send_matrix(m, 1'b1, n);
        wait_done(2, 1'b0, 1'b1);

        // Reset in the middle of emission discards the rest of the matrix.
        m = '0;
        m = set_el(m, 0, 1, 32'd11);
        m = set_el(m, 1, 2, 32'd22);
        m = set_el(m, 3, 3, 32'd33);
        send_matrix(m, 1'b0, n);
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        chk("mid_rst_out_last", 64'(out_last), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_nnz", 64'(nnz_count), 64'(0));
        chk("mid_rst_ovf", 64'(overflow), 64'(0));
        chk("mid_rst_pending", 64'(sb.size()), 64'(1));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("after_rst_in_ready", 64'(in_ready), 64'(1));
        m = set_el('0, 0, 0, 32'd9);
        send_matrix(m, 1'b0, n);
        wait_done(1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
